ham_15_11_dec_pipe: RTL

//  Receive-side companion of the Hamming (15,11) SEC encoder. Accepts 15-bit codewords,

---
 rtl/ham_pkg.sv | 21 ++
 rtl/ham_15_11_corr.sv | 31 +++
 rtl/ham_15_11_dec_pipe.sv | 124 ++++++++++++
 3 files changed

// File: rtl/ham_pkg.sv
// Shared Hamming (15,11) definitions for the encoder and decoder sides.
//   HAM15_W / HAM11_W : codeword and data widths
//   S*_MASK           : codeword bits covered by each syndrome/parity bit
//   ham15_syndrome()  : 4-bit syndrome {S8,S4,S2,S1} of a 15-bit codeword
// Bit k of a codeword is Hamming position k+1.
package ham_pkg;

  localparam int HAM15_W = 15;
  localparam int HAM11_W = 11;

  // Each mask selects the positions whose index has the matching bit set.
  localparam logic [HAM15_W-1:0] S1_MASK = 15'h5555; // bits 0,2,4,...,14
  localparam logic [HAM15_W-1:0] S2_MASK = 15'h6666; // bits 1,2,5,6,9,10,13,14
  localparam logic [HAM15_W-1:0] S4_MASK = 15'h7878; // bits 3..6, 11..14
  localparam logic [HAM15_W-1:0] S8_MASK = 15'h7F80; // bits 7..14

  function automatic logic [3:0] ham15_syndrome(input logic [HAM15_W-1:0] cw);
    return {^(cw & S8_MASK), ^(cw & S4_MASK), ^(cw & S2_MASK), ^(cw & S1_MASK)};
  endfunction

endpackage

// File: rtl/ham_15_11_corr.sv
// Combinational single-bit correction and data extraction for Hamming (15,11).
//   cw_i         : received codeword {D11..D5,P8,D4,D3,D2,P4,D1,P2,P1}
//   syndrome_i   : syndrome of cw_i; non-zero value = faulty position (1..15)
//   correct_en_i : 1 flips the addressed bit, 0 passes the codeword through
//   data_o       : extracted data {D11..D1}
module ham_15_11_corr
  import ham_pkg::*;
(
  input  logic [HAM15_W-1:0] cw_i,
  input  logic [3:0]         syndrome_i,
  input  logic               correct_en_i,
  output logic [HAM11_W-1:0] data_o
);

  logic [HAM15_W-1:0] flip_mask;
  logic [HAM15_W-1:0] fixed_cw;

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    flip_mask = '0;
    if (correct_en_i && (syndrome_i != 4'd0)) begin
      flip_mask = HAM15_W'(1) << (syndrome_i - 4'd1);
    end
    fixed_cw = cw_i ^ flip_mask;
  end

  // Data bits sit at the non-power-of-two positions.
  assign data_o = {fixed_cw[14:8], fixed_cw[6:4], fixed_cw[2]};

endmodule

// File: rtl/ham_15_11_dec_pipe.sv
// Two-stage pipelined Hamming (15,11) SEC decoder with valid/ready flow control
// and a saturating error counter.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   data_i/valid_i      : incoming codeword; ready_o signals acceptance
//   data_o/valid_o      : decoded 11-bit data; ready_i from the consumer
//   err_o, syndrome_o   : non-zero syndrome flag and the syndrome itself
//   clr_cnt_i           : synchronous clear of err_cnt_o (wins over increment)
//   err_cnt_o           : number of delivered words with err_o=1, saturating
// Stage 1 holds the codeword and syndrome, stage 2 the corrected result.
// Double-bit errors are miscorrected but still flagged (no DED).
module ham_15_11_dec_pipe
  import ham_pkg::*;
#(
  parameter bit CORRECT_EN = 1'b1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [HAM15_W-1:0]   data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [HAM11_W-1:0]   data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 err_o,
  output logic [3:0]           syndrome_o,
  input  logic                 clr_cnt_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  // Stage 1
  logic               s1_valid_q, s1_valid_d;
  logic [HAM15_W-1:0] s1_cw_q,    s1_cw_d;
  logic [3:0]         s1_syn_q,   s1_syn_d;
  // Stage 2 (output)
  logic               s2_valid_q, s2_valid_d;
  logic [HAM11_W-1:0] s2_data_q,  s2_data_d;
  logic               s2_err_q,   s2_err_d;
  logic [3:0]         s2_syn_q,   s2_syn_d;
  // Error counter
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic               adv1, adv2;
  logic               out_xfer;
  logic [HAM11_W-1:0] corr_data;

  // A stage may load when its downstream frees up or when it is empty.
  assign adv2     = ready_i | ~s2_valid_q;
  assign adv1     = adv2 | ~s1_valid_q;
  assign ready_o  = adv1;
  assign out_xfer = s2_valid_q & ready_i;

  ham_15_11_corr u_corr (
    .cw_i         (s1_cw_q),
    .syndrome_i   (s1_syn_q),
    .correct_en_i (CORRECT_EN),
    .data_o       (corr_data)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_cw_d    = s1_cw_q;
    s1_syn_d   = s1_syn_q;
    if (adv1) begin
      s1_valid_d = valid_i;
      s1_cw_d    = data_i;
      s1_syn_d   = ham15_syndrome(data_i);
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    s2_syn_d   = s2_syn_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = corr_data;
      s2_err_d   = |s1_syn_q;
      s2_syn_d   = s1_syn_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (out_xfer && s2_err_q && (cnt_q != {ERR_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others. The datapath registers are reset as well
  // because data_o, err_o and syndrome_o are required to read zero after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_syn_q   <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_cw_q    <= s1_cw_d;
      s1_syn_q   <= s1_syn_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
      s2_syn_q   <= s2_syn_d;
      cnt_q      <= cnt_d;
    end
  end

  assign valid_o    = s2_valid_q;
  assign data_o     = s2_data_q;
  assign err_o      = s2_err_q;
  assign syndrome_o = s2_syn_q;
  assign err_cnt_o  = cnt_q;

endmodule
